// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS32 pipeline.
// Tracks EX/MEM destinations, drives the EX operand forward selects and the stall/flush controls.
module hazard_fwd_ctrl #(
    parameter int unsigned REG_AW        = 5,
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_reg,
    input  logic              id_is_load,
    input  logic              id_is_muldiv,
    input  logic              ex_branch_taken,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              bubble_id_ex,
    output logic              flush_if_id,
    output logic              hold_ex,
    output logic              bubble_ex_mem,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
);

    localparam logic [3:0] CntInit = 4'(MULDIV_CYCLES - 1);

    localparam logic [1:0] SelReg    = 2'b00;
    localparam logic [1:0] SelExAlu  = 2'b01;
    localparam logic [1:0] SelMemAlu = 2'b10;
    localparam logic [1:0] SelMemLd  = 2'b11;

    logic              ex_valid_q, ex_valid_d;
    logic              ex_wr_en_q, ex_wr_en_d;
    logic [REG_AW-1:0] ex_wr_reg_q, ex_wr_reg_d;
    logic              ex_is_load_q, ex_is_load_d;
    logic              ex_is_muldiv_q, ex_is_muldiv_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic [REG_AW-1:0] mem_wr_reg_q, mem_wr_reg_d;
    logic              mem_is_load_q, mem_is_load_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        fwd_a_q, fwd_a_d;
    logic [1:0]        fwd_b_q, fwd_b_d;

    logic rs_ex, rt_ex, rs_mem, rt_mem;
    logic load_use, busy;
    logic [1:0] sel_a_nxt, sel_b_nxt;

    // Register $0 is hardwired, so it never matches a producer.
    assign rs_ex  = id_uses_rs && (id_rs != '0) && ex_valid_q && ex_wr_en_q &&
                    (ex_wr_reg_q == id_rs);
    assign rt_ex  = id_uses_rt && (id_rt != '0) && ex_valid_q && ex_wr_en_q &&
                    (ex_wr_reg_q == id_rt);
    assign rs_mem = id_uses_rs && (id_rs != '0) && mem_valid_q && mem_wr_en_q &&
                    (mem_wr_reg_q == id_rs);
    assign rt_mem = id_uses_rt && (id_rt != '0) && mem_valid_q && mem_wr_en_q &&
                    (mem_wr_reg_q == id_rt);

    assign load_use = id_valid && ex_valid_q && ex_is_load_q && (rs_ex || rt_ex);
    assign busy     = (cnt_q != 4'd0);

    // Youngest producer wins; an EX load never reaches here because load_use bubbles first.
    always_comb begin
        sel_a_nxt = SelReg;
        if (rs_ex && !ex_is_load_q) begin
            sel_a_nxt = SelExAlu;
        end else if (rs_mem) begin
            sel_a_nxt = mem_is_load_q ? SelMemLd : SelMemAlu;
        end
        sel_b_nxt = SelReg;
        if (rt_ex && !ex_is_load_q) begin
            sel_b_nxt = SelExAlu;
        end else if (rt_mem) begin
            sel_b_nxt = mem_is_load_q ? SelMemLd : SelMemAlu;
        end
    end

    always_comb begin
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        bubble_id_ex  = 1'b0;
        flush_if_id   = 1'b0;
        hold_ex       = 1'b0;
        bubble_ex_mem = 1'b0;
        if (busy) begin
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            hold_ex       = 1'b1;
            bubble_ex_mem = 1'b1;
        end else if (ex_branch_taken) begin
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end else if (load_use) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end
    end

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_wr_en_d     = ex_wr_en_q;
        ex_wr_reg_d    = ex_wr_reg_q;
        ex_is_load_d   = ex_is_load_q;
        ex_is_muldiv_d = ex_is_muldiv_q;
        mem_valid_d    = ex_valid_q;
        mem_wr_en_d    = ex_wr_en_q;
        mem_wr_reg_d   = ex_wr_reg_q;
        mem_is_load_d  = ex_is_load_q;
        cnt_d          = cnt_q;
        fwd_a_d        = fwd_a_q;
        fwd_b_d        = fwd_b_q;
        if (busy) begin
            // EX is frozen on the mul/div; MEM receives a bubble each cycle.
            mem_valid_d   = 1'b0;
            mem_wr_en_d   = 1'b0;
            mem_wr_reg_d  = '0;
            mem_is_load_d = 1'b0;
            cnt_d         = cnt_q - 4'd1;
        end else if (ex_branch_taken || load_use) begin
            ex_valid_d     = 1'b0;
            ex_wr_en_d     = 1'b0;
            ex_wr_reg_d    = '0;
            ex_is_load_d   = 1'b0;
            ex_is_muldiv_d = 1'b0;
            fwd_a_d        = SelReg;
            fwd_b_d        = SelReg;
        end else begin
            ex_valid_d     = id_valid;
            ex_wr_en_d     = id_wr_en;
            ex_wr_reg_d    = id_wr_reg;
            ex_is_load_d   = id_is_load;
            ex_is_muldiv_d = id_is_muldiv;
            fwd_a_d        = sel_a_nxt;
            fwd_b_d        = sel_b_nxt;
            if (id_valid && id_is_muldiv) begin
                cnt_d = CntInit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_wr_en_q     <= 1'b0;
            ex_wr_reg_q    <= '0;
            ex_is_load_q   <= 1'b0;
            ex_is_muldiv_q <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_wr_en_q    <= 1'b0;
            mem_wr_reg_q   <= '0;
            mem_is_load_q  <= 1'b0;
            cnt_q          <= 4'd0;
            fwd_a_q        <= SelReg;
            fwd_b_q        <= SelReg;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_wr_en_q     <= ex_wr_en_d;
            ex_wr_reg_q    <= ex_wr_reg_d;
            ex_is_load_q   <= ex_is_load_d;
            ex_is_muldiv_q <= ex_is_muldiv_d;
            mem_valid_q    <= mem_valid_d;
            mem_wr_en_q    <= mem_wr_en_d;
            mem_wr_reg_q   <= mem_wr_reg_d;
            mem_is_load_q  <= mem_is_load_d;
            cnt_q          <= cnt_d;
            fwd_a_q        <= fwd_a_d;
            fwd_b_q        <= fwd_b_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: directed pipeline scenarios plus random traffic
// checked against an instruction-level pipeline model.
module tb_hazard_fwd_ctrl;

    localparam int unsigned MULDIV_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load, id_is_muldiv;
    logic [4:0] id_rs, id_rt, id_wr_reg;
    logic       ex_branch_taken;
    logic       stall_pc, stall_if_id, bubble_id_ex, flush_if_id, hold_ex, bubble_ex_mem;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    hazard_fwd_ctrl #(.REG_AW(5), .MULDIV_CYCLES(MULDIV_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
        .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv),
        .ex_branch_taken(ex_branch_taken),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
        .flush_if_id(flush_if_id), .hold_ex(hold_ex), .bubble_ex_mem(bubble_ex_mem),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rs, rt;
        logic       uses_rs, uses_rt, wr_en;
        logic [4:0] rd;
        logic       is_load, is_muldiv, br;
    } stim_t;

    typedef struct {
        logic       valid, wr_en;
        logic [4:0] rd;
        logic       is_load;
    } slot_t;

    typedef struct {
        string      name;
        logic [9:0] v;
    } exp_t;

    // Model: what sits in EX and MEM, remaining mul/div hold cycles, and the selects now in EX.
    slot_t      m_ex, m_mem;
    int         m_hold;
    logic [1:0] m_sel_a, m_sel_b;
    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic slot_t empty_slot();
        slot_t s;
        s.valid = 1'b0; s.wr_en = 1'b0; s.rd = 5'd0; s.is_load = 1'b0;
        return s;
    endfunction

    function automatic bit writes(slot_t p, logic used, logic [4:0] src);
        return used && src != 0 && p.valid && p.wr_en && p.rd == src;
    endfunction

    function automatic logic [1:0] pick(logic used, logic [4:0] src);
        if (writes(m_ex, used, src) && !m_ex.is_load) return 2'd1;
        if (writes(m_mem, used, src)) return m_mem.is_load ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_ex = empty_slot(); m_mem = empty_slot(); m_hold = 0;
        m_sel_a = 2'd0; m_sel_b = 2'd0;
    endtask

    task automatic drive(stim_t s);
        id_valid = s.valid; id_rs = s.rs; id_rt = s.rt;
        id_uses_rs = s.uses_rs; id_uses_rt = s.uses_rt;
        id_wr_en = s.wr_en; id_wr_reg = s.rd;
        id_is_load = s.is_load; id_is_muldiv = s.is_muldiv;
        ex_branch_taken = s.br;
    endtask

    function automatic stim_t ins(logic v, int rs, int rt, logic urs, logic urt, logic we, int rd,
                                  logic ld, logic md, logic br);
        stim_t s;
        s.valid = v; s.rs = 5'(rs); s.rt = 5'(rt); s.uses_rs = urs; s.uses_rt = urt;
        s.wr_en = we; s.rd = 5'(rd); s.is_load = ld; s.is_muldiv = md; s.br = br;
        return s;
    endfunction

    // One cycle: present ID contents, queue what the DUT must show, then advance the model.
    task automatic step(string name, stim_t s);
        exp_t  e;
        bit    lu;
        logic  sp, sif, bie, fif, hx, bem;
        slot_t nxt;
        @(posedge clk);
        #1;
        drive(s);
        lu = s.valid && m_ex.is_load &&
             (writes(m_ex, s.uses_rs, s.rs) || writes(m_ex, s.uses_rt, s.rt));
        {sp, sif, bie, fif, hx, bem} = 6'b0;
        if (m_hold > 0) {sp, sif, hx, bem} = 4'b1111;
        else if (s.br) {fif, bie} = 2'b11;
        else if (lu) {sp, sif, bie} = 3'b111;
        e.name = name;
        e.v = {sp, sif, bie, fif, hx, bem, m_sel_a, m_sel_b};
        sb.push_back(e);
        if (m_hold > 0) begin
            m_hold--;
            m_mem = empty_slot();
        end else if (s.br || lu) begin
            m_mem = m_ex;
            m_ex = empty_slot();
            m_sel_a = 2'd0; m_sel_b = 2'd0;
        end else begin
            m_sel_a = pick(s.uses_rs, s.rs);
            m_sel_b = pick(s.uses_rt, s.rt);
            nxt.valid = s.valid; nxt.wr_en = s.wr_en; nxt.rd = s.rd; nxt.is_load = s.is_load;
            m_mem = m_ex;
            m_ex = nxt;
            if (s.valid && s.is_muldiv) m_hold = MULDIV_CYCLES - 1;
        end
    endtask

    task automatic check_zero(string name);
        n_cmp++;
        if ({stall_pc, stall_if_id, bubble_id_ex, flush_if_id, hold_ex, bubble_ex_mem,
             fwd_a_sel, fwd_b_sel} !== 10'd0) begin
            n_bad++;
            $display("FAIL %s: outputs=%b required=%b", name,
                     {stall_pc, stall_if_id, bubble_id_ex, flush_if_id, hold_ex, bubble_ex_mem,
                      fwd_a_sel, fwd_b_sel}, 10'd0);
        end
    endtask

    // Asynchronous reset applied mid-cycle, checked before any clock edge.
    task automatic async_reset(string name);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        drive(ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check_zero(name);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: every cycle with a queued expectation, compare the DUT outputs.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [9:0] act;
            e = sb.pop_front();
            act = {stall_pc, stall_if_id, bubble_id_ex, flush_if_id, hold_ex, bubble_ex_mem,
                   fwd_a_sel, fwd_b_sel};
            n_cmp++;
            if (act !== e.v) begin
                n_bad++;
                $display("FAIL %s: {spc,sifid,bidex,fifid,hold,bexmem,a,b}=%b required=%b",
                         e.name, act, e.v);
            end
        end
    end

    stim_t nop;

    initial begin
        model_reset();
        nop = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(nop);
        #1;
        check_zero("reset_state");
        #12;
        rst_n = 1'b1;

        // add $3,$1,$2 ; sub $4,$3,$5 -> sub in EX with a=01, b=00
        step("add3", ins(1, 1, 2, 1, 1, 1, 3, 0, 0, 0));
        step("sub_uses3", ins(1, 3, 5, 1, 1, 1, 4, 0, 0, 0));
        step("sub_ex_fwd01", nop);
        // add $3 ; nop ; or $6,$7,$3 -> b=10
        step("add3b", ins(1, 1, 2, 1, 1, 1, 3, 0, 0, 0));
        step("nop_gap", nop);
        step("or_uses3", ins(1, 7, 3, 1, 1, 1, 6, 0, 0, 0));
        step("or_ex_fwd10", nop);
        // lw $8 ; add $9,$8,$8 -> one stall then a=b=11
        step("lw8", ins(1, 1, 0, 1, 0, 1, 8, 1, 0, 0));
        step("add_lu_stall", ins(1, 8, 8, 1, 1, 1, 9, 0, 0, 0));
        step("add_after_bubble", ins(1, 8, 8, 1, 1, 1, 9, 0, 0, 0));
        step("add_ex_fwd11", nop);
        // writes to $0 never forward; two writers of $5 -> youngest (01)
        step("add0", ins(1, 1, 2, 1, 1, 1, 0, 0, 0, 0));
        step("use0", ins(1, 0, 0, 1, 1, 1, 7, 0, 0, 0));
        step("w5_old", ins(1, 1, 2, 1, 1, 1, 5, 0, 0, 0));
        step("w5_new", ins(1, 1, 2, 1, 1, 1, 5, 0, 0, 0));
        step("use5", ins(1, 5, 5, 1, 1, 1, 6, 0, 0, 0));
        step("use5_ex_fwd01", nop);
        // MULT occupies EX for 3 extra cycles, then normal advance
        step("mult", ins(1, 1, 2, 1, 1, 0, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++) step("mult_busy", ins(1, 3, 4, 1, 1, 1, 9, 0, 0, 0));
        step("mult_done", ins(1, 3, 4, 1, 1, 1, 9, 0, 0, 0));
        step("post_mult", nop);
        // branch taken alongside a load-use -> flush wins
        step("lw10", ins(1, 1, 0, 1, 0, 1, 10, 1, 0, 0));
        step("br_vs_lu", ins(1, 10, 0, 1, 0, 1, 11, 0, 0, 1));
        step("after_br", nop);
        // reset in the middle of a MULT
        step("mult2", ins(1, 1, 2, 1, 1, 0, 0, 0, 1, 0));
        step("mult2_busy", nop);
        async_reset("reset_mid_mult");
        step("post_reset_idle", ins(1, 1, 2, 1, 1, 1, 3, 0, 0, 0));
        step("post_reset_next", nop);

        // random traffic on a small register set to force frequent hazards
        for (int i = 0; i < 600; i++) begin
            stim_t s;
            if ($urandom_range(0, 149) == 0) async_reset("rand_reset");
            s.valid = ($urandom_range(0, 9) != 0);
            s.rs = 5'($urandom_range(0, 3));
            s.rt = 5'($urandom_range(0, 3));
            s.uses_rs = ($urandom_range(0, 4) != 0);
            s.uses_rt = ($urandom_range(0, 2) != 0);
            s.wr_en = ($urandom_range(0, 4) != 0);
            s.rd = 5'($urandom_range(0, 3));
            s.is_load = ($urandom_range(0, 3) == 0);
            s.is_muldiv = !s.is_load && ($urandom_range(0, 19) == 0);
            s.br = ($urandom_range(0, 11) == 0);
            step("random", s);
        end
        step("drain", nop);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
